// File: rtl/mole_round_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mole_round_engine                                             |
// | Purpose  : Whack-a-mole round controller. Fetches SEQ_LEN-step mole      |
// |            patterns from the random source and shows one mole at a time. |
// |            It judges keypad presses against a per-step tick timeout and  |
// |            keeps round and hit counts for the game.                      |
// | Ports    : clk, reset (sync, active-high)                                |
// |            game_start           - start/restart pulse (IDLE/DONE only)   |
// |            pattern_data/_valid  - pattern in, pattern_ready handshake    |
// |            pattern_req          - 1-cycle request for a new pattern      |
// |            key_data/key_valid   - keypad code and strobe                 |
// |            mole_out/mole_valid  - current mole position                  |
// |            hit, miss            - 1-cycle judgement pulses               |
// |            round_count, hit_count, tick_count, game_end - status         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mole_round_engine #(
  parameter int KEY_W         = 4,
  parameter int SEQ_LEN       = 8,
  parameter int TICK_DIV      = 5_000_000,
  parameter int TIMEOUT_TICKS = 3,
  parameter int ROUNDS        = 30,
  parameter int CNT_W         = 7,
  localparam int TICK_W       = $clog2(TIMEOUT_TICKS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     game_start,
  input  logic [SEQ_LEN*KEY_W-1:0] pattern_data,
  input  logic                     pattern_valid,
  output logic                     pattern_ready,
  output logic                     pattern_req,
  input  logic [KEY_W-1:0]         key_data,
  input  logic                     key_valid,
  output logic [KEY_W-1:0]         mole_out,
  output logic                     mole_valid,
  output logic                     hit,
  output logic                     miss,
  output logic [CNT_W-1:0]         round_count,
  output logic [CNT_W-1:0]         hit_count,
  output logic [TICK_W-1:0]        tick_count,
  output logic                     game_end
);

  localparam int STEP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int PRE_W  = $clog2(TICK_DIV);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEQ_LEN - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0]  ROUNDS_C  = CNT_W'(ROUNDS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_PAT = 2'd1,
    SHOW     = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                     state;
  logic [SEQ_LEN*KEY_W-1:0]   pattern;
  logic [STEP_W-1:0]          step;
  logic [PRE_W-1:0]           prescaler;

  logic [STEP_W-1:0]          step_nxt;
  logic [KEY_W-1:0]           next_mole;
  logic [CNT_W-1:0]           round_inc;
  logic [CNT_W-1:0]           hit_inc;
  logic                       timeout;

  assign step_nxt  = step + 1'b1;
  assign next_mole = pattern[step_nxt*KEY_W +: KEY_W];
  assign round_inc = (round_count == CNT_MAX) ? round_count : round_count + 1'b1;
  assign hit_inc   = (hit_count   == CNT_MAX) ? hit_count   : hit_count   + 1'b1;
  // The timeout is judged on the prescaler wrap that would carry tick_count
  // up to TIMEOUT_TICKS, so the miss pulse lands exactly TICK_DIV*TIMEOUT_TICKS
  // cycles after the mole appears. A key on that same cycle takes priority.
  assign timeout   = (prescaler == PRE_LAST) && (tick_count == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pattern       <= '0;
      step          <= '0;
      prescaler     <= '0;
      tick_count    <= '0;
      mole_out      <= '0;
      mole_valid    <= 1'b0;
      pattern_ready <= 1'b0;
      pattern_req   <= 1'b0;
      hit           <= 1'b0;
      miss          <= 1'b0;
      round_count   <= '0;
      hit_count     <= '0;
      game_end      <= 1'b0;
    end else begin
      hit         <= 1'b0;
      miss        <= 1'b0;
      pattern_req <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (game_start) begin
            round_count   <= '0;
            hit_count     <= '0;
            game_end      <= 1'b0;
            pattern_req   <= 1'b1;
            pattern_ready <= 1'b1;
            state         <= WAIT_PAT;
          end
        end

        WAIT_PAT: begin
          if (pattern_valid) begin
            pattern       <= pattern_data;
            step          <= '0;
            prescaler     <= '0;
            tick_count    <= '0;
            mole_out      <= pattern_data[KEY_W-1:0];
            mole_valid    <= 1'b1;
            pattern_ready <= 1'b0;
            state         <= SHOW;
          end
        end

        SHOW: begin
          if (key_valid || timeout) begin
            if (key_valid && (key_data == mole_out)) begin
              hit       <= 1'b1;
              hit_count <= hit_inc;
            end else begin
              miss <= 1'b1;
            end
            round_count <= round_inc;
            prescaler   <= '0;
            tick_count  <= '0;
            if (round_inc == ROUNDS_C) begin
              game_end   <= 1'b1;
              mole_valid <= 1'b0;
              state      <= DONE;
            end else if (step == LAST_STEP) begin
              pattern_req   <= 1'b1;
              pattern_ready <= 1'b1;
              mole_valid    <= 1'b0;
              state         <= WAIT_PAT;
            end else begin
              step     <= step_nxt;
              mole_out <= next_mole;
            end
          end else if (prescaler == PRE_LAST) begin
            prescaler  <= '0;
            tick_count <= tick_count + 1'b1;
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mole_round_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mole_round_engine                                          |
// | Purpose  : Directed self-checking bench for mole_round_engine with       |
// |            TICK_DIV=4, TIMEOUT_TICKS=3, SEQ_LEN=8, ROUNDS=10.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mole_round_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        game_start;
  logic [31:0] pattern_data;
  logic        pattern_valid;
  logic        pattern_ready;
  logic        pattern_req;
  logic [3:0]  key_data;
  logic        key_valid;
  logic [3:0]  mole_out;
  logic        mole_valid;
  logic        hit;
  logic        miss;
  logic [6:0]  round_count;
  logic [6:0]  hit_count;
  logic [1:0]  tick_count;
  logic        game_end;

  int tests  = 0;
  int failed = 0;
  logic early_miss;

  mole_round_engine #(
    .KEY_W(4), .SEQ_LEN(8), .TICK_DIV(4), .TIMEOUT_TICKS(3), .ROUNDS(10), .CNT_W(7)
  ) dut (
    .clk(clk), .reset(reset), .game_start(game_start),
    .pattern_data(pattern_data), .pattern_valid(pattern_valid),
    .pattern_ready(pattern_ready), .pattern_req(pattern_req),
    .key_data(key_data), .key_valid(key_valid),
    .mole_out(mole_out), .mole_valid(mole_valid),
    .hit(hit), .miss(miss),
    .round_count(round_count), .hit_count(hit_count),
    .tick_count(tick_count), .game_end(game_end)
  );

  always #5 clk = ~clk;

  // Advance one clock and land 1ns after the edge: outputs are stable here
  // and inputs driven here are sampled by the following edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mole"},   32'(mole_out), 32'd0);
    chk({tag, "_mvalid"}, 32'(mole_valid), 32'd0);
    chk({tag, "_ready"},  32'(pattern_ready), 32'd0);
    chk({tag, "_req"},    32'(pattern_req), 32'd0);
    chk({tag, "_hit"},    32'(hit), 32'd0);
    chk({tag, "_miss"},   32'(miss), 32'd0);
    chk({tag, "_round"},  32'(round_count), 32'd0);
    chk({tag, "_hits"},   32'(hit_count), 32'd0);
    chk({tag, "_tick"},   32'(tick_count), 32'd0);
    chk({tag, "_end"},    32'(game_end), 32'd0);
  endtask

  // Runs n cycles with no key and flags any miss seen along the way.
  task automatic quiet_cycles(input int n);
    early_miss = 1'b0;
    for (int k = 0; k < n; k++) begin
      cyc();
      if (miss) early_miss = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; game_start = 1'b0; pattern_data = '0; pattern_valid = 1'b0;
    key_data = '0; key_valid = 1'b0;
    cyc(); cyc();
    chk_idle_outputs("rst");
    reset = 1'b0;

    // ---- Scenario 1: full pattern of correct keys ----
    game_start = 1'b1;
    cyc();
    game_start = 1'b0;
    chk("s1_req", 32'(pattern_req), 32'd1);
    chk("s1_ready", 32'(pattern_ready), 32'd1);
    pattern_valid = 1'b1; pattern_data = 32'h7654_3210;
    cyc();
    pattern_valid = 1'b0;
    chk("s1_mole0", 32'(mole_out), 32'd0);
    chk("s1_mvalid0", 32'(mole_valid), 32'd1);
    chk("s1_ready_lo", 32'(pattern_ready), 32'd0);
    chk("s1_req_once", 32'(pattern_req), 32'd0);
    for (int s = 0; s < 8; s++) begin
      key_valid = 1'b1; key_data = 4'(s);
      cyc();
      key_valid = 1'b0;
      chk("s1_hit", 32'(hit), 32'd1);
      chk("s1_miss", 32'(miss), 32'd0);
      chk("s1_hits", 32'(hit_count), 32'(s + 1));
      chk("s1_round", 32'(round_count), 32'(s + 1));
      if (s < 7) begin
        chk("s1_mole", 32'(mole_out), 32'(s + 1));
        chk("s1_req_lo", 32'(pattern_req), 32'd0);
      end else begin
        chk("s1_req_step7", 32'(pattern_req), 32'd1);
        chk("s1_ready_step7", 32'(pattern_ready), 32'd1);
        chk("s1_mvalid_step7", 32'(mole_valid), 32'd0);
      end
    end

    // ---- Scenario 5: finish the 10-round game on a second pattern ----
    game_start = 1'b1;                         // ignored in WAIT_PAT
    cyc();
    game_start = 1'b0;
    chk("s5_req_1cyc", 32'(pattern_req), 32'd0);
    chk("s5_still_wait", 32'(pattern_ready), 32'd1);
    chk("s5_round_kept", 32'(round_count), 32'd8);
    pattern_valid = 1'b1; pattern_data = 32'h0000_00A9;
    cyc();
    chk("s5_mole9", 32'(mole_out), 32'd9);
    pattern_data = 32'hFFFF_FFFF;              // stays valid in SHOW: must not latch
    key_valid = 1'b1; key_data = 4'h9;
    cyc();
    pattern_valid = 1'b0;
    chk("s5_hit9", 32'(hit), 32'd1);
    chk("s5_moleA", 32'(mole_out), 32'hA);
    chk("s5_round9", 32'(round_count), 32'd9);
    key_data = 4'h1; game_start = 1'b1;        // wrong key; start ignored in SHOW
    cyc();
    key_valid = 1'b0; game_start = 1'b0;
    chk("s5_miss10", 32'(miss), 32'd1);
    chk("s5_round10", 32'(round_count), 32'd10);
    chk("s5_hits9", 32'(hit_count), 32'd9);
    chk("s5_end", 32'(game_end), 32'd1);
    chk("s5_mvalid_lo", 32'(mole_valid), 32'd0);
    chk("s5_no_req", 32'(pattern_req), 32'd0);
    key_valid = 1'b1; key_data = 4'hA;         // keys after game end are ignored
    cyc();
    key_valid = 1'b0;
    chk("s5_ign_hit", 32'(hit), 32'd0);
    chk("s5_ign_miss", 32'(miss), 32'd0);
    chk("s5_ign_round", 32'(round_count), 32'd10);
    chk("s5_end_held", 32'(game_end), 32'd1);
    game_start = 1'b1;
    cyc();
    game_start = 1'b0;
    chk("s5_rs_round", 32'(round_count), 32'd0);
    chk("s5_rs_hits", 32'(hit_count), 32'd0);
    chk("s5_rs_end", 32'(game_end), 32'd0);
    chk("s5_rs_req", 32'(pattern_req), 32'd1);

    // ---- Scenario 2: timeouts with no keys ----
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    game_start = 1'b1;
    cyc();
    game_start = 1'b0;
    pattern_valid = 1'b1; pattern_data = 32'h7654_3210;
    cyc();
    pattern_valid = 1'b0;
    chk("s2_tick0", 32'(tick_count), 32'd0);
    quiet_cycles(11);
    chk("s2_no_early0", 32'(early_miss), 32'd0);
    chk("s2_tick2", 32'(tick_count), 32'd2);
    cyc();
    chk("s2_miss0", 32'(miss), 32'd1);
    chk("s2_hit0", 32'(hit), 32'd0);
    chk("s2_round1", 32'(round_count), 32'd1);
    chk("s2_mole1", 32'(mole_out), 32'd1);
    chk("s2_tick_clr", 32'(tick_count), 32'd0);
    quiet_cycles(11);
    chk("s2_no_early1", 32'(early_miss), 32'd0);
    cyc();
    chk("s2_miss1", 32'(miss), 32'd1);
    chk("s2_round2", 32'(round_count), 32'd2);
    chk("s2_mole2", 32'(mole_out), 32'd2);

    // ---- Scenario 3: wrong key ----
    key_valid = 1'b1; key_data = 4'd5;
    cyc();
    key_valid = 1'b0;
    chk("s3_miss", 32'(miss), 32'd1);
    chk("s3_hit", 32'(hit), 32'd0);
    chk("s3_hits", 32'(hit_count), 32'd0);
    chk("s3_round", 32'(round_count), 32'd3);
    chk("s3_mole3", 32'(mole_out), 32'd3);
    cyc();
    chk("s3_miss_1cyc", 32'(miss), 32'd0);

    // ---- Scenario 4: correct key on the exact timeout cycle ----
    quiet_cycles(10);
    chk("s4_no_early", 32'(early_miss), 32'd0);
    chk("s4_tick2", 32'(tick_count), 32'd2);
    key_valid = 1'b1; key_data = 4'd3;
    cyc();
    key_valid = 1'b0;
    chk("s4_hit", 32'(hit), 32'd1);
    chk("s4_miss", 32'(miss), 32'd0);
    chk("s4_hits", 32'(hit_count), 32'd1);
    chk("s4_round", 32'(round_count), 32'd4);
    chk("s4_mole4", 32'(mole_out), 32'd4);
    cyc();
    chk("s4_no_second_miss", 32'(miss), 32'd0);
    chk("s4_round_once", 32'(round_count), 32'd4);

    // ---- Scenario 6: reset mid-SHOW at step 4 ----
    chk("s6_mvalid_pre", 32'(mole_valid), 32'd1);
    reset = 1'b1; key_valid = 1'b1; key_data = 4'd4;
    cyc();
    reset = 1'b0; key_valid = 1'b0;
    chk_idle_outputs("s6");
    pattern_valid = 1'b1; pattern_data = 32'h1111_1111;   // ignored in IDLE
    cyc();
    pattern_valid = 1'b0;
    chk("s6_idle_mvalid", 32'(mole_valid), 32'd0);
    chk("s6_idle_mole", 32'(mole_out), 32'd0);
    chk("s6_idle_ready", 32'(pattern_ready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
